// File: rtl/scalar_mult_ctrl_pkg.sv
// Shared widths, FSM encodings and modular helpers for the scalar-multiply slice.
// MAX_BITS is the operand width; the 8-bit default covers the small test curves.
package scalar_mult_ctrl_pkg;

   localparam int MAX_BITS = 8;
   localparam int IDX_W    = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_DBL_GO,
      S_DBL_WAIT,
      S_ADD_GO,
      S_ADD_WAIT,
      S_DONE
   } ctrl_state_t;

   typedef enum logic [1:0] {
      P_IDLE,
      P_INV,
      P_RES
   } pop_state_t;

   // All helpers assume both operands are already reduced below p.
   function automatic logic [MAX_BITS-1:0] mod_add(input logic [MAX_BITS-1:0] a,
                                                   input logic [MAX_BITS-1:0] b,
                                                   input logic [MAX_BITS-1:0] p);
      logic [MAX_BITS:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, p}) s = s - {1'b0, p};
      return MAX_BITS'(s);
   endfunction

   function automatic logic [MAX_BITS-1:0] mod_sub(input logic [MAX_BITS-1:0] a,
                                                   input logic [MAX_BITS-1:0] b,
                                                   input logic [MAX_BITS-1:0] p);
      logic [MAX_BITS:0] d;
      if (a >= b) d = {1'b0, a} - {1'b0, b};
      else        d = {1'b0, a} + {1'b0, p} - {1'b0, b};
      return MAX_BITS'(d);
   endfunction

   function automatic logic [MAX_BITS-1:0] mod_mul(input logic [MAX_BITS-1:0] a,
                                                   input logic [MAX_BITS-1:0] b,
                                                   input logic [MAX_BITS-1:0] p);
      logic [2*MAX_BITS-1:0] prod;
      logic [2*MAX_BITS-1:0] m;
      prod = {{MAX_BITS{1'b0}}, a} * {{MAX_BITS{1'b0}}, b};
      if (p == '0) m = '0;
      else         m = prod % {{MAX_BITS{1'b0}}, p};
      return MAX_BITS'(m);
   endfunction

endpackage

// File: rtl/scalar_mult_ctrl_point_operation.sv
// Affine point add / double mod p. Lambda's denominator is inverted by a
// one-candidate-per-cycle search, so latency varies with the operands.
module point_operation
   import scalar_mult_ctrl_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                i_add_start,
   input  logic                i_double_start,
   input  logic [MAX_BITS-1:0] i_a,
   input  logic [MAX_BITS-1:0] i_p,
   input  logic [MAX_BITS-1:0] i_x1,
   input  logic [MAX_BITS-1:0] i_y1,
   input  logic [MAX_BITS-1:0] i_x2,
   input  logic [MAX_BITS-1:0] i_y2,
   output logic                o_finish,
   output logic [MAX_BITS-1:0] o_result_x,
   output logic [MAX_BITS-1:0] o_result_y
);

   pop_state_t          r_state, w_state_next;
   logic [MAX_BITS-1:0] r_p, r_x1, r_y1, r_x2, r_num, r_den, r_t, r_lam, r_rx, r_ry;
   logic                r_finish;
   logic                w_start, w_hit, w_giveup;
   logic [MAX_BITS-1:0] w_sq, w_num, w_den, w_x3, w_y3;

   assign w_start  = i_add_start | i_double_start;
   assign w_sq     = mod_mul(i_x1, i_x1, i_p);
   assign w_num    = i_double_start ? mod_add(mod_add(w_sq, w_sq, i_p), mod_add(w_sq, i_a, i_p), i_p)
                                    : mod_sub(i_y2, i_y1, i_p);
   assign w_den    = i_double_start ? mod_add(i_y1, i_y1, i_p) : mod_sub(i_x2, i_x1, i_p);
   assign w_hit    = (mod_mul(r_den, r_t, r_p) == MAX_BITS'(1));
   // A zero denominator never hits; give up at p-1 so the unit always finishes.
   assign w_giveup = (r_t >= r_p - MAX_BITS'(1));
   assign w_x3     = mod_sub(mod_sub(mod_mul(r_lam, r_lam, r_p), r_x1, r_p), r_x2, r_p);
   assign w_y3     = mod_sub(mod_mul(r_lam, mod_sub(r_x1, w_x3, r_p), r_p), r_y1, r_p);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= P_IDLE;
      else      r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         P_IDLE:  if (w_start) w_state_next = P_INV;
         P_INV:   if (w_hit || w_giveup) w_state_next = P_RES;
         P_RES:   w_state_next = P_IDLE;
         default: w_state_next = P_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_p      <= '0;
         r_x1     <= '0;
         r_y1     <= '0;
         r_x2     <= '0;
         r_num    <= '0;
         r_den    <= '0;
         r_t      <= '0;
         r_lam    <= '0;
         r_rx     <= '0;
         r_ry     <= '0;
         r_finish <= 1'b0;
      end else begin
         r_finish <= 1'b0;
         case (r_state)
            P_IDLE: if (w_start) begin
               r_p   <= i_p;
               r_x1  <= i_x1;
               r_y1  <= i_y1;
               r_x2  <= i_double_start ? i_x1 : i_x2;
               r_num <= w_num;
               r_den <= w_den;
               r_t   <= MAX_BITS'(1);
            end
            P_INV: begin
               if (w_hit)         r_lam <= mod_mul(r_num, r_t, r_p);
               else if (w_giveup) r_lam <= '0;
               else               r_t   <= r_t + MAX_BITS'(1);
            end
            P_RES: begin
               r_rx     <= w_x3;
               r_ry     <= w_y3;
               r_finish <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign o_finish   = r_finish;
   assign o_result_x = r_rx;
   assign o_result_y = r_ry;

endmodule

// File: rtl/scalar_mult_ctrl.sv
// Left-to-right double-and-add controller around point_operation; the point at
// infinity is tracked here because point_operation cannot represent it.
module scalar_mult_ctrl
   import scalar_mult_ctrl_pkg::*;
#(
   parameter int IDX_W = scalar_mult_ctrl_pkg::IDX_W
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                i_start,
   input  logic [MAX_BITS-1:0] i_k,
   input  logic [MAX_BITS-1:0] i_a,
   input  logic [MAX_BITS-1:0] i_p,
   input  logic [MAX_BITS-1:0] i_px,
   input  logic [MAX_BITS-1:0] i_py,
   output logic                o_busy,
   output logic                o_finish,
   output logic [MAX_BITS-1:0] o_x,
   output logic [MAX_BITS-1:0] o_y,
   output logic                o_inf
);

   ctrl_state_t         r_state, w_state_next;
   logic [MAX_BITS-1:0] r_k, r_a, r_p, r_px, r_py, r_rx, r_ry, r_x, r_y;
   logic [IDX_W-1:0]    r_idx;
   logic                r_inf, r_o_inf;
   logic                w_kbit, w_idx_zero, w_add_phase;
   logic                w_load, w_dec, w_set_p, w_cap, w_done;
   logic                w_add_start, w_dbl_start, w_po_finish;
   logic [MAX_BITS-1:0] w_x2, w_y2, w_res_x, w_res_y;

   assign w_kbit      = |(r_k & (MAX_BITS'(1) << r_idx));
   assign w_idx_zero  = (r_idx == '0);
   assign w_add_phase = (r_state == S_ADD_GO) || (r_state == S_ADD_WAIT);
   assign w_dbl_start = (r_state == S_DBL_GO);
   assign w_add_start = (r_state == S_ADD_GO);
   // Operands come only from latched registers and stay put through the WAIT states.
   assign w_x2        = w_add_phase ? r_px : r_rx;
   assign w_y2        = w_add_phase ? r_py : r_ry;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_dec        = 1'b0;
      w_set_p      = 1'b0;
      w_cap        = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE: if (i_start) begin
            w_load       = 1'b1;
            w_state_next = S_SCAN;
         end
         S_SCAN: begin
            w_set_p = w_kbit;
            if (w_idx_zero) begin
               w_done       = 1'b1;
               w_state_next = S_DONE;
            end else begin
               w_dec = 1'b1;
               if (w_kbit) w_state_next = S_DBL_GO;
            end
         end
         S_DBL_GO: w_state_next = S_DBL_WAIT;
         S_DBL_WAIT: if (w_po_finish) begin
            w_cap = 1'b1;
            if (w_kbit) begin
               w_state_next = S_ADD_GO;
            end else if (w_idx_zero) begin
               w_done       = 1'b1;
               w_state_next = S_DONE;
            end else begin
               w_dec        = 1'b1;
               w_state_next = S_DBL_GO;
            end
         end
         S_ADD_GO: w_state_next = S_ADD_WAIT;
         S_ADD_WAIT: if (w_po_finish) begin
            w_cap = 1'b1;
            if (w_idx_zero) begin
               w_done       = 1'b1;
               w_state_next = S_DONE;
            end else begin
               w_dec        = 1'b1;
               w_state_next = S_DBL_GO;
            end
         end
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_k     <= '0;
         r_a     <= '0;
         r_p     <= '0;
         r_px    <= '0;
         r_py    <= '0;
         r_rx    <= '0;
         r_ry    <= '0;
         r_idx   <= '0;
         r_inf   <= 1'b0;
         r_x     <= '0;
         r_y     <= '0;
         r_o_inf <= 1'b0;
      end else begin
         if (w_load) begin
            r_k   <= i_k;
            r_a   <= i_a;
            r_p   <= i_p;
            r_px  <= i_px;
            r_py  <= i_py;
            r_idx <= IDX_W'(MAX_BITS - 1);
            r_inf <= 1'b1;
         end
         if (w_dec) r_idx <= r_idx - IDX_W'(1);
         if (w_set_p) begin
            r_rx  <= r_px;
            r_ry  <= r_py;
            r_inf <= 1'b0;
         end
         if (w_cap) begin
            r_rx <= w_res_x;
            r_ry <= w_res_y;
         end
         // Result registers load on the way into DONE so they are valid with o_finish.
         if (w_done) begin
            if (w_cap) begin
               r_x     <= w_res_x;
               r_y     <= w_res_y;
               r_o_inf <= 1'b0;
            end else if (w_set_p) begin
               r_x     <= r_px;
               r_y     <= r_py;
               r_o_inf <= 1'b0;
            end else begin
               r_x     <= '0;
               r_y     <= '0;
               r_o_inf <= r_inf;
            end
         end
      end
   end

   point_operation u_point_operation (
      .clk            (clk),
      .rst            (rst),
      .i_add_start    (w_add_start),
      .i_double_start (w_dbl_start),
      .i_a            (r_a),
      .i_p            (r_p),
      .i_x1           (r_rx),
      .i_y1           (r_ry),
      .i_x2           (w_x2),
      .i_y2           (w_y2),
      .o_finish       (w_po_finish),
      .o_result_x     (w_res_x),
      .o_result_y     (w_res_y)
   );

   assign o_busy   = (r_state != S_IDLE) && (r_state != S_DONE);
   assign o_finish = (r_state == S_DONE);
   assign o_x      = r_x;
   assign o_y      = r_y;
   assign o_inf    = r_o_inf;

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Bench for scalar_mult_ctrl on y^2 = x^3 + 2x + 2 mod 17, generator (5,1), order 19.
// Reference: k*P as k repeated affine additions with explicit infinity.
`timescale 1ns/1ps
module tb_scalar_mult_ctrl;
   import scalar_mult_ctrl_pkg::*;

   localparam int P_MOD  = 17;
   localparam int A_COEF = 2;
   localparam int GX     = 5;
   localparam int GY     = 1;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                i_start = 1'b0;
   logic [MAX_BITS-1:0] i_k = '0, i_a = '0, i_p = '0, i_px = '0, i_py = '0;
   logic                o_busy, o_finish, o_inf;
   logic [MAX_BITS-1:0] o_x, o_y;

   int n_tests = 0;
   int n_fail  = 0;
   int n_dbl   = 0;
   int n_add   = 0;
   int n_both  = 0;
   int n_fin   = 0;

   scalar_mult_ctrl #(.IDX_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .i_start  (i_start),
      .i_k      (i_k),
      .i_a      (i_a),
      .i_p      (i_p),
      .i_px     (i_px),
      .i_py     (i_py),
      .o_busy   (o_busy),
      .o_finish (o_finish),
      .o_x      (o_x),
      .o_y      (o_y),
      .o_inf    (o_inf)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- start-line / finish monitor ----------------
   always @(negedge clk) begin
      if (dut.w_dbl_start) n_dbl++;
      if (dut.w_add_start) n_add++;
      if (dut.w_dbl_start && dut.w_add_start) n_both++;
      if (o_finish) n_fin++;
   end

   // ---------------- checker ----------------
   task automatic check_val(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int md(input int v);
      int r;
      r = v % P_MOD;
      if (r < 0) r += P_MOD;
      return r;
   endfunction

   function automatic int inv(input int v);
      for (int t = 1; t < P_MOD; t++)
         if (md(v * t) == 1) return t;
      return 0;
   endfunction

   task automatic ec_add(input int x1, input int y1, input bit inf1,
                         input int x2, input int y2, input bit inf2,
                         output int x3, output int y3, output bit inf3);
      int lam;
      if (inf1) begin
         x3 = x2; y3 = y2; inf3 = inf2;
      end else if (inf2) begin
         x3 = x1; y3 = y1; inf3 = inf1;
      end else if (x1 == x2 && md(y1 + y2) == 0) begin
         x3 = 0; y3 = 0; inf3 = 1'b1;
      end else begin
         if (x1 == x2) lam = md(md(3 * x1 * x1 + A_COEF) * inv(md(2 * y1)));
         else          lam = md(md(y2 - y1) * inv(md(x2 - x1)));
         x3   = md(lam * lam - x1 - x2);
         y3   = md(lam * (x1 - x3) - y1);
         inf3 = 1'b0;
      end
   endtask

   task automatic ref_mul(input int k, input int bx, input int by,
                          output int rx, output int ry, output bit rinf);
      int tx, ty;
      bit tinf;
      rx = 0; ry = 0; rinf = 1'b1;
      for (int i = 0; i < k; i++) begin
         ec_add(rx, ry, rinf, bx, by, 1'b0, tx, ty, tinf);
         rx = tx; ry = ty; rinf = tinf;
      end
   endtask

   // ---------------- driver ----------------
   // poke_k >= 0 re-pulses i_start mid-run; glitch scrambles the base-point inputs.
   task automatic run_op(input int k, input int bx, input int by, input string tag,
                         input int poke_k, input bit glitch, output int cyc);
      int ex, ey, h, w, d0, a0, b0, f0;
      bit einf;
      ref_mul(k, bx, by, ex, ey, einf);
      h = 0; w = 0;
      for (int i = 0; i < MAX_BITS; i++)
         if (((k >> i) & 1) == 1) begin h = i; w++; end
      @(negedge clk);
      i_k = MAX_BITS'(k); i_px = MAX_BITS'(bx); i_py = MAX_BITS'(by); i_start = 1'b1;
      d0 = n_dbl; a0 = n_add; b0 = n_both; f0 = n_fin;
      @(negedge clk);
      i_start = 1'b0;
      cyc = 1;
      if (glitch) begin
         i_px = MAX_BITS'($urandom_range(0, 16));
         i_py = MAX_BITS'($urandom_range(0, 16));
         i_k  = MAX_BITS'($urandom_range(0, 255));
      end
      while (!o_finish && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (poke_k >= 0 && cyc == 10) begin i_start = 1'b1; i_k = MAX_BITS'(poke_k); end
         if (poke_k >= 0 && cyc == 11) i_start = 1'b0;
      end
      i_start = 1'b0;
      check_val({tag, "_finish"}, int'(o_finish), 1);
      check_val({tag, "_x"}, int'(o_x), ex);
      check_val({tag, "_y"}, int'(o_y), ey);
      check_val({tag, "_inf"}, int'(o_inf), int'(einf));
      check_val({tag, "_busy_at_done"}, int'(o_busy), 0);
      @(negedge clk);
      check_val({tag, "_dbl_calls"}, n_dbl - d0, (k == 0) ? 0 : h);
      check_val({tag, "_add_calls"}, n_add - a0, (k == 0) ? 0 : w - 1);
      check_val({tag, "_both_starts"}, n_both - b0, 0);
      check_val({tag, "_one_finish"}, n_fin - f0, 1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int cyc, f0, j, k, bx, by;
      bit binf;
      i_a = MAX_BITS'(A_COEF);
      i_p = MAX_BITS'(P_MOD);
      repeat (3) @(negedge clk);
      check_val("reset_x", int'(o_x), 0);
      check_val("reset_y", int'(o_y), 0);
      check_val("reset_inf", int'(o_inf), 0);
      check_val("reset_busy", int'(o_busy), 0);
      check_val("reset_finish", int'(o_finish), 0);
      rst = 1'b1;
      @(negedge clk);

      run_op(1, GX, GY, "k1", -1, 1'b0, cyc);
      check_val("k1_latency", cyc, MAX_BITS + 1);
      check_val("k1_x_direct", int'(o_x), 5);
      run_op(2, GX, GY, "k2", -1, 1'b0, cyc);
      check_val("k2_y_direct", int'(o_y), 3);
      run_op(5, GX, GY, "k5", -1, 1'b0, cyc);
      check_val("k5_y_direct", int'(o_y), 16);
      run_op(18, GX, GY, "k18", -1, 1'b0, cyc);
      run_op(7, GX, GY, "k7", -1, 1'b0, cyc);
      check_val("k7_x_direct", int'(o_x), 0);
      run_op(0, GX, GY, "k0", -1, 1'b0, cyc);
      check_val("k0_latency", cyc, MAX_BITS + 1);

      // Second start while busy must be ignored.
      run_op(5, GX, GY, "k5_poke", 3, 1'b0, cyc);
      f0 = n_fin;
      repeat (60) @(negedge clk);
      check_val("poke_no_extra_finish", n_fin - f0, 0);

      run_op(7, GX, GY, "k7_glitch", -1, 1'b1, cyc);

      // Reset in the middle of a doubling.
      @(negedge clk);
      i_k = 8'd5; i_px = MAX_BITS'(GX); i_py = MAX_BITS'(GY); i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      cyc = 0;
      while (dut.r_state != S_DBL_WAIT && cyc < 200) begin @(negedge clk); cyc++; end
      check_val("reach_dbl_wait", int'(dut.r_state == S_DBL_WAIT), 1);
      rst = 1'b0;
      #1;
      check_val("midrst_x", int'(o_x), 0);
      check_val("midrst_y", int'(o_y), 0);
      check_val("midrst_busy", int'(o_busy), 0);
      @(negedge clk);
      rst = 1'b1;
      f0 = n_fin;
      repeat (60) @(negedge clk);
      check_val("midrst_no_finish", n_fin - f0, 0);
      run_op(2, GX, GY, "k2_after_rst", -1, 1'b0, cyc);

      // Random scalars on random group points.
      for (int r = 0; r < 12; r++) begin
         j = $urandom_range(1, 18);
         k = $urandom_range(0, 18);
         ref_mul(j, GX, GY, bx, by, binf);
         run_op(k, bx, by, $sformatf("rnd%0d_k%0d_j%0d", r, k, j), -1, 1'b0, cyc);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/scalar_mult_ctrl.md
Name: scalar_mult_ctrl

Overview:
- Computes Q = k·P on a short-Weierstrass curve mod p using left-to-right double-and-add.
- Sits directly upstream of point_operation: drives its i_add_start / i_double_start and operands, and consumes o_finish / o_result_x / o_result_y.
- Tracks the point at infinity itself, because point_operation has no infinity representation.
- Top of the ECC datapath; the host/key-exchange controller calls it.

Parameters:
- IDX_W, 8, width of the bit-index counter; must satisfy 2^IDX_W >= `MAX_BITS (`MAX_BITS comes from ECCDefine.vh).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- i_start  in  1  one-cycle request; accepted only in IDLE
- i_k  in  `MAX_BITS  scalar; legal range 0 <= k < group order n
- i_a  in  `MAX_BITS  curve coefficient a, already reduced mod p
- i_p  in  `MAX_BITS  prime modulus
- i_px  in  `MAX_BITS  base point x, < p
- i_py  in  `MAX_BITS  base point y, < p
- o_busy  out  1  high while an operation is in progress
- o_finish  out  1  one-cycle pulse when the result is valid
- o_x  out  `MAX_BITS  result x
- o_y  out  `MAX_BITS  result y
- o_inf  out  1  result is the point at infinity (o_x = o_y = 0)

Behaviour:
- Reset (async, rst=0): state IDLE; all outputs 0; all internal registers 0.
  - The same rst drives the point_operation instance, so reset mid-operation aborts cleanly and no stale finish pulse appears afterwards.
- IDLE, i_start=1:
  - Latch k, a, p, Px, Py into registers. Inputs are don't-care after this cycle, and point_operation is fed only from these registers.
  - Set idx = `MAX_BITS-1, o_busy=1, go to SCAN.
- i_start while not in IDLE: ignored; latched values are unchanged.
- SCAN: one bit per cycle.
  - k[idx]=0 and idx>0: decrement idx.
  - k[idx]=0 and idx=0 (k=0): o_inf=1, o_x=o_y=0, go to DONE.
  - k[idx]=1: set R=(Px,Py), inf=0. If idx=0, go to DONE; else decrement idx and go to DBL_GO.
- DBL_GO (1 cycle):
  - Drive x1=y1=x2=y2=R and pulse i_double_start for exactly one cycle.
  - Go to DBL_WAIT.
- DBL_WAIT: hold operands stable; wait for the point_operation o_finish pulse.
  - On that pulse, capture R = result.
  - If k[idx]=1, go to ADD_GO.
  - Else, if idx=0 go to DONE; else decrement idx and go to DBL_GO.
- ADD_GO (1 cycle):
  - Drive x1,y1 = R and x2,y2 = P; pulse i_add_start for one cycle.
  - Go to ADD_WAIT.
- ADD_WAIT: on o_finish, capture R.
  - If idx=0 go to DONE; else decrement idx and go to DBL_GO.
- DONE (1 cycle):
  - o_x, o_y = R, or 0 if inf.
  - o_finish=1 and o_busy=0 in the same cycle; return to IDLE.
  - o_x, o_y, o_inf hold until the next accepted start.
- Never assert i_add_start and i_double_start together; never pulse either while point_operation is busy.
- Correctness precondition: 1 <= k < n with n prime and odd.
  - This guarantees no intermediate R+P has R=±P and no doubling has y=0, so no exceptional-case logic is needed here.
  - Out-of-range k gives an undefined point but must still terminate with an o_finish pulse.
- Latency, with h = index of the MSB set in k and w = popcount(k):
  - Total = 1 (accept) + (`MAX_BITS-h) SCAN cycles + h·(DBL cost) + (w-1)·(ADD cost) + 1 (DONE).
  - DBL cost = 1 + point_operation double latency; ADD cost = 1 + add latency.
  - k=1: no point_operation calls at all.

Decomposition:
- Add state encodings (S_IDLE … S_DONE) and IDX_W to ECCDefine.vh alongside `MAX_BITS.
- Instantiate point_operation as the single sub-module; no other sub-module.
- The datapath is registers plus muxes only; no arithmetic beyond the idx decrement.

Test Plan:
Curve y² = x³+2x+2 mod 17, a=2, p=17, P=(5,1), n=19.
- k=1 -> o_finish with (5,1), o_inf=0; point_operation start lines never asserted.
- k=2 -> (6,3); exactly one double, zero adds.
- k=5 -> (9,16); sequence DBL, DBL, ADD; check no simultaneous add/double start.
- k=18 -> (5,16); k=7 -> (0,6); compare against a software reference model.
- k=0 -> o_inf=1, o_x=o_y=0, o_finish after `MAX_BITS+1 cycles; no point_operation calls.
- Robustness:
  - Pulse i_start with k=3 while busy on k=5 -> only (9,16) is produced.
  - Change i_px mid-operation -> result unaffected.
  - Drop rst during DBL_WAIT -> outputs return to 0, no o_finish; a restart with k=2 yields (6,3).
